// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the data-memory responder: FSM state
//                encoding, default geometry/latency, the captured-request
//                record and the address error predicate.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Default build parameters
    localparam int DMEM_DEPTH   = 128;
    localparam int DMEM_LATENCY = 3;

    // Request as captured on acceptance
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    // A request is in error when it is not word aligned or its word index
    // falls outside the storage array.
    function automatic logic dmem_addr_err(input logic [31:0] addr,
                                           input int unsigned depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Word-addressed data memory with a fixed, parameterised
//                response latency. One request at a time: accept in IDLE,
//                count down in BUSY, present the response in RESP until the
//                CPU takes it.
//  Ports       : clk_i          clock, rising edge
//                rst_i          synchronous reset, active low
//                req_valid_i    request present
//                req_ready_o    request can be accepted (IDLE only)
//                req_write_i    1 = store, 0 = load
//                req_addr_i     byte address
//                req_wdata_i    store data
//                resp_valid_o   response present (RESP only)
//                resp_ready_i   CPU accepts response
//                resp_rdata_o   load data, 0 for stores and errors
//                resp_err_o     misaligned or out-of-range request
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEPTH,
    parameter int LATENCY = DMEM_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o
);

    localparam int         c_IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    dmem_req_t          hold_q, hold_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;
    logic [31:0]        mem_q [DEPTH];

    logic               w_err;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]        w_rd;
    logic               w_mem_we;

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;

    // Everything downstream of acceptance works off the captured request
    // only, so the live request inputs are free to change while busy.
    assign w_err = dmem_addr_err(hold_q.addr, DEPTH);
    assign w_idx = hold_q.addr[c_IDX_W+1:2];
    assign w_rd  = mem_q[w_idx];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        w_mem_we = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    hold_d = '{write: req_write_i,
                               addr:  req_addr_i,
                               wdata: req_wdata_i};
                    cnt_d   = c_CNT_INIT;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    // Storage access happens on the BUSY->RESP edge so the
                    // response data appears together with resp_valid_o.
                    state_d = ST_RESP;
                    if (w_err) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                    end else if (hold_q.write) begin
                        w_mem_we = 1'b1;
                        rdata_d  = 32'd0;
                        err_d    = 1'b0;
                    end else begin
                        rdata_d = w_rd;
                        err_d   = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= '0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            // Storage is cleared too, which also drops any pending store.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (w_mem_we) begin
                mem_q[w_idx] <= hold_q.wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Scoreboard bench for dmem_responder. Expected responses are
//                queued when a request is driven and compared when the DUT
//                hands a response over. A second instance built with
//                LATENCY=1 exercises back-to-back request spacing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        l1_req_valid = 1'b0;
    logic        l1_req_ready;
    logic        l1_resp_valid;
    logic [31:0] l1_resp_rdata;
    logic        l1_resp_err;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   seen = 1'b0;

    dmem_responder #(.DEPTH(128), .LATENCY(LAT)) u_dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err)
    );

    dmem_responder #(.DEPTH(128), .LATENCY(1)) u_dut_l1 (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (l1_req_valid),
        .req_ready_o  (l1_req_ready),
        .req_write_i  (1'b0),
        .req_addr_i   (32'h4),
        .req_wdata_i  (32'd0),
        .resp_valid_o (l1_resp_valid),
        .resp_ready_i (1'b1),
        .resp_rdata_o (l1_resp_rdata),
        .resp_err_o   (l1_resp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: actual=0x%08h expected=0x%08h", tag, act, want);
        end
    endtask

    // Response monitor: latency on first sight of resp_valid, data and
    // error on the handshake.
    always @(negedge clk) begin
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    check({exp_q[0].tag, "_lat"}, 32'(cyc), 32'(exp_q[0].cyc));
                    seen = 1'b1;
                end
                if (resp_ready) begin
                    mon_e = exp_q.pop_front();
                    check({mon_e.tag, "_rdata"}, resp_rdata, mon_e.rdata);
                    check({mon_e.tag, "_err"}, {31'd0, resp_err}, {31'd0, mon_e.err});
                    seen = 1'b0;
                end
            end
        end
    end

    // One request on the main DUT. stall > 0 holds resp_ready low in RESP
    // for that many sampled cycles while driving a decoy request.
    task automatic tx(input string tag, input bit sync, input logic w,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee, input int stall);
        int k;
        exp_t e;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_wdata  = d;
        resp_ready = (stall == 0);
        e.tag   = tag;
        e.rdata = er;
        e.err   = ee;
        e.cyc   = cyc + 1 + LAT;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (stall > 0) begin
            k = 0;
            while (!resp_valid && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (!resp_valid) begin
                check({tag, "_valid_timeout"}, 32'd0, 32'd1);
            end else begin
                @(posedge clk);
                #1;
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = 32'h0;
                req_wdata = 32'hFFFF_FFFF;
                repeat (stall) begin
                    @(negedge clk);
                    check({tag, "_stall_valid"}, {31'd0, resp_valid}, 32'd1);
                    check({tag, "_stall_rdata"}, resp_rdata, er);
                    check({tag, "_stall_err"}, {31'd0, resp_err}, {31'd0, ee});
                    check({tag, "_stall_reqrdy"}, {31'd0, req_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        k = 0;
        while (exp_q.size() != 0 && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            check({tag, "_resp_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            seen = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int noresp;
        int acc[$];
        int rv[$];
        int nmin;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", {31'd0, resp_err}, 32'd0);

        // First request on the first edge after reset release
        @(posedge clk);
        #1;
        rst = 1'b1;
        tx("st10",     1'b0, 1'b1, 32'h10,  32'hDEAD_BEEF, 32'd0,         1'b0, 0);
        tx("ld10",     1'b1, 1'b0, 32'h10,  32'd0,         32'hDEAD_BEEF, 1'b0, 0);
        tx("ld13",     1'b1, 1'b0, 32'h13,  32'd0,         32'd0,         1'b1, 0);
        tx("ld10b",    1'b1, 1'b0, 32'h10,  32'd0,         32'hDEAD_BEEF, 1'b0, 0);
        tx("st200",    1'b1, 1'b1, 32'h200, 32'hCAFE_F00D, 32'd0,         1'b1, 0);
        tx("ld10stl",  1'b1, 1'b0, 32'h10,  32'd0,         32'hDEAD_BEEF, 1'b0, 5);
        tx("ld00",     1'b1, 1'b0, 32'h0,   32'd0,         32'd0,         1'b0, 0);
        tx("st1fc",    1'b1, 1'b1, 32'h1FC, 32'h0BAD_F00D, 32'd0,         1'b0, 0);
        tx("ld1fc",    1'b1, 1'b0, 32'h1FC, 32'd0,         32'h0BAD_F00D, 1'b0, 0);
        tx("st_mis2",  1'b1, 1'b1, 32'h1FE, 32'h1111_2222, 32'd0,         1'b1, 0);
        tx("ld1fc_b",  1'b1, 1'b0, 32'h1FC, 32'd0,         32'h0BAD_F00D, 1'b0, 0);

        // Reset one cycle after accepting a store: no response, no write
        @(posedge clk);
        #1;
        check("rst_tx_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst       = 1'b0;
        noresp    = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) noresp++;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tx("ld20_rst", 1'b0, 1'b0, 32'h20,  32'd0,         32'd0,         1'b0, 0);
        check("rst_noresp", 32'(noresp), 32'd0);
        tx("ld10_rst", 1'b1, 1'b0, 32'h10,  32'd0,         32'd0,         1'b0, 0);

        // LATENCY=1 instance: back-to-back loads with resp_ready high
        @(posedge clk);
        #1;
        l1_req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (l1_req_ready) acc.push_back(cyc + 1);
            if (l1_resp_valid) rv.push_back(cyc);
        end
        @(posedge clk);
        #1;
        l1_req_valid = 1'b0;
        check("l1_naccept", 32'(acc.size()), 32'd4);
        check("l1_nresp", 32'(rv.size()), 32'd4);
        nmin = (acc.size() < rv.size()) ? acc.size() : rv.size();
        for (int i = 0; i < nmin; i++) begin
            check("l1_lat", 32'(rv[i] - acc[i]), 32'd1);
        end
        for (int i = 1; i < acc.size(); i++) begin
            check("l1_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 128, number of 32-bit words in storage (power of two, 4..1024).
REQ-002 Parameter LATENCY, default 3, cycles from request acceptance to response valid (1..15).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-low.
REQ-005 req_valid_i  input  1  CPU-side request present.
REQ-006 req_ready_o  output  1  responder can accept a request this cycle.
REQ-007 req_write_i  input  1  1 = store word, 0 = load word.
REQ-008 req_addr_i  input  32  byte address.
REQ-009 req_wdata_i  input  32  store data.
REQ-010 resp_valid_o  output  1  response present.
REQ-011 resp_ready_i  input  1  CPU accepts response.
REQ-012 resp_rdata_o  output  32  load data; 0 for stores and errors.
REQ-013 resp_err_o  output  1  request was misaligned or out of range.

Function
REQ-014 States SHALL be IDLE, BUSY, RESP; req_ready_o = 1 only in IDLE; resp_valid_o = 1 only in RESP.
REQ-015 Request accepted on an edge where req_valid_i & req_ready_o; write, addr, wdata captured into holding registers; state -> BUSY; latency counter loaded with LATENCY-1.
REQ-016 In BUSY: counter = 0 -> RESP on next edge; otherwise decrement, remain BUSY; resp_valid_o therefore rises exactly LATENCY edges after the acceptance edge.
REQ-017 Word index = captured addr[31:2]; error = (addr[1:0] != 0) or (index >= DEPTH).
REQ-018 On the BUSY->RESP edge: non-error store writes wdata to mem[index]; non-error load registers mem[index] into resp_rdata_o; error registers rdata 0, err 1, no storage change.
REQ-019 Store response: rdata 0, err 0 (unless error).
REQ-020 In RESP: resp_rdata_o and resp_err_o held stable until resp_valid_o & resp_ready_i; on that edge -> IDLE, resp_rdata_o and resp_err_o cleared to 0.
REQ-021 Minimum request-to-request spacing is LATENCY+2 cycles with resp_ready_i held high; no acceptance during BUSY or RESP.
REQ-022 Input changes while not in IDLE SHALL be ignored; captured values used exclusively.
REQ-023 Load following store to same word returns the stored value.

Reset
REQ-024 While rst_i = 0 at an edge: state -> IDLE, counter 0, holding registers 0, resp_rdata_o 0, resp_err_o 0, all DEPTH words 0.
REQ-025 Reset in BUSY or RESP abandons the transaction; a pending store is not performed; no response is issued afterward.
REQ-026 First acceptance possible on the first edge with rst_i = 1 (req_ready_o = 1 in that cycle).

Structure
REQ-027 Shared package dmem_pkg SHALL hold state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and defaults DMEM_DEPTH=128, DMEM_LATENCY=3.
REQ-028 Single flat module; storage array, FSM, counter inline; no sub-module.

Verification
REQ-029 Reset, then store addr 0x10 data 0xDEADBEEF, load addr 0x10 -> load resp_rdata_o 0xDEADBEEF, err 0, resp_valid_o 3 edges after acceptance.
REQ-030 Load addr 0x13 -> err 1, rdata 0; subsequent load 0x10 still 0xDEADBEEF.
REQ-031 Store addr 0x200 (index 128, DEPTH 128) -> err 1; load addr 0x000 returns 0 (no wrap-around write).
REQ-032 Hold resp_ready_i = 0 for 5 cycles in RESP -> resp_valid_o, rdata, err stable; req_ready_o 0; new req_valid_i ignored.
REQ-033 Assert rst_i = 0 one cycle after accepting store addr 0x20 data 0x1234 -> no response; load 0x20 after reset returns 0.
REQ-034 LATENCY=1 build: accept at edge N -> resp_valid_o high after edge N+1; back-to-back requests with resp_ready_i = 1 accepted every 3 cycles.
